jt12_cendiv_multi: RTL

// - Parametrised clock-enable divider: NUM_OUT independent cen outputs, each dividing the master cen by a runtime-programmable ratio.
// - Successor to the fixed OPN/SSG/timer prescaler. Adds per-channel divisor writes, glitch-free update at the period boundary, write acknowledge and a global phase re-sync.
// - Sits between the core master cen and the FM, SSG, timer and ADPCM blocks.

---
 rtl/jt12_cendiv_multi.sv | 88 ++++++++
 1 files changed

// File: rtl/jt12_cendiv_multi.sv
// jt12_cendiv_multi
// Clock-enable divider with NUM_OUT independent outputs. Each channel divides
// the master cen by (pres+1), where pres is a runtime-programmable field.
// Written fields are held in a shadow register and only take effect at a
// period boundary (counter wrap, or a global sync). That boundary also
// produces a one-cycle div_ack pulse.
//
// Optional build macro: JT12_CENDIV_FAST_EN
//   When defined, every cen_out simply follows cen, one clk later, so that
//   simulations run fast. Counters, shadow fields, pend and div_ack keep
//   their normal behaviour, so the register interface still behaves the same.

module jt12_cendiv_multi #(
  parameter int NUM_OUT = 3,
  parameter int CNT_W   = 4,
  parameter int SEL_W   = 2,
  parameter logic [NUM_OUT*CNT_W-1:0] RST_DIV = {4'd7, 4'd5, 4'd11}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               sync,
  input  logic               div_wr,
  input  logic [SEL_W-1:0]   div_sel,
  input  logic [CNT_W-1:0]   div_val,
  output logic [NUM_OUT-1:0] cen_out,
  output logic [NUM_OUT-1:0] div_ack
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] pres_reg;
      logic [CNT_W-1:0] sh_reg;
      logic             pend_reg;
      logic             out_reg;
      logic             ack_reg;
      logic             wr_hit;
      logic             at_end;
      logic             boundary;
      logic             apply;

      // A select value beyond NUM_OUT matches no channel, so such writes vanish.
      assign wr_hit   = div_wr && (div_sel == SEL_W'(gi));
      assign at_end   = (cnt_reg == pres_reg);
      // Period boundary: natural wrap, or a forced restart by sync.
      assign boundary = cen && (sync || at_end);
      // Apply uses the shadow value from before any same-cycle write.
      assign apply    = boundary && pend_reg;

      // Channel state: counter, active/shadow fields, pending flag and outputs.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          pres_reg <= RST_DIV[gi*CNT_W +: CNT_W];
          sh_reg   <= RST_DIV[gi*CNT_W +: CNT_W];
          pend_reg <= 1'b0;
          out_reg  <= 1'b0;
          ack_reg  <= 1'b0;
        end else begin
          if (cen) begin
            cnt_reg <= boundary ? '0 : cnt_reg + 1'b1;
          end
          if (apply) begin
            pres_reg <= sh_reg;
          end
          if (wr_hit) begin
            sh_reg <= div_val;
          end
          // A write landing on the apply cycle re-arms pend for the next wrap.
          pend_reg <= wr_hit | (pend_reg & ~apply);
          ack_reg  <= apply;
`ifdef JT12_CENDIV_FAST_EN
          out_reg  <= cen;
`else
          // Decided from the pre-update counter, so sync does not mask it.
          out_reg  <= cen & (cnt_reg == '0);
`endif
        end
      end

      assign cen_out[gi] = out_reg;
      assign div_ack[gi] = ack_reg;
    end
  endgenerate

endmodule
